gate_sweep: RTL

GATE_SWEEP -- requirements
Module: gate_sweep

---
 rtl/gate_sweep.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gate_sweep.sv
// gate_sweep: exhaustive truth-table sweep of one NIN-input logic gate, counting output mismatches.
// Build option: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_sweep #(
    parameter int NIN    = 2,
    parameter int HOLD   = 4,
    parameter int ECNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    output logic [NIN-1:0]    stim,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ECNT_W-1:0] err_cnt,
    output logic [NIN-1:0]    first_fail,
    output logic [1:0]        dbg_state
);
    // Handshake: start is a request that is accepted only while busy=0 (IDLE); the FIN cycle
    // is followed by a one-cycle done pulse, and pass/err_cnt/first_fail stay valid from that
    // pulse until the next accepted start.

    localparam int                HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]    HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [ECNT_W-1:0] ECNT_MAX  = {ECNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_op_ok;
    logic [HCW-1:0]    r_hold;
    logic [NIN-1:0]    r_stim;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ECNT_W-1:0] r_err;
    logic [NIN-1:0]    r_first;

    logic w_op_legal;
    logic w_exp;
    logic w_sample;
    logic w_mismatch;
    logic w_last_vec;
    logic w_stop;

    assign w_op_legal = (op <= 3'd5);
    assign w_sample   = (r_hold == HOLD_LAST);
    assign w_mismatch = (dut_y != w_exp);
    assign w_last_vec = &r_stim;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign w_stop = w_last_vec || w_mismatch;
`else
    assign w_stop = w_last_vec;
`endif

    // Reference response of the gate under test for the vector currently applied.
    always_comb begin
        w_exp = 1'b0;
        case (r_op)
            3'd0:    w_exp = &r_stim;
            3'd1:    w_exp = |r_stim;
            3'd2:    w_exp = ^r_stim;
            3'd3:    w_exp = ~(&r_stim);
            3'd4:    w_exp = ~(|r_stim);
            3'd5:    w_exp = ~(^r_stim);
            default: w_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_op_ok <= 1'b0;
            r_hold  <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_op_ok <= w_op_legal;
                        r_stim  <= '0;
                        r_hold  <= '0;
                        r_err   <= '0;
                        r_first <= '0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= w_op_legal ? S_RUN : S_FIN;
                    end
                end
                S_RUN: begin
                    if (w_sample) begin
                        if (w_mismatch) begin
                            if (r_err != ECNT_MAX) begin
                                r_err <= r_err + ECNT_W'(1);
                            end
                            if (r_err == '0) begin
                                r_first <= r_stim;
                            end
                        end
                        // The failing or final vector stays on stim when the sweep ends.
                        if (w_stop) begin
                            r_state <= S_FIN;
                        end else begin
                            r_stim <= r_stim + NIN'(1);
                            r_hold <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + HCW'(1);
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_pass  <= r_op_ok && (r_err == '0);
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stim       = r_stim;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err;
    assign first_fail = r_first;
    assign dbg_state  = r_state;

endmodule
